// File: rtl/ace_ccu_snoop_ctrl.sv
// ACE cache-coherency snoop controller: broadcasts a read as snoops to every
// other master, collects responses, and returns data from a snooped cache
// (CD path) or from memory (mem path), one transaction at a time.
module ace_ccu_snoop_ctrl #(
  parameter int unsigned NoPorts   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned PortIdxW  = $clog2(NoPorts)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  // arbitrated read request
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  input  logic [AddrWidth-1:0]           ar_addr_i,
  input  logic [IdWidth-1:0]             ar_id_i,
  input  logic [PortIdxW-1:0]            ar_port_i,
  input  logic [3:0]                     ar_snoop_i,
  // snoop address
  output logic [NoPorts-1:0]             ac_valid_o,
  input  logic [NoPorts-1:0]             ac_ready_i,
  output logic [AddrWidth-1:0]           ac_addr_o,
  output logic [3:0]                     ac_snoop_o,
  // snoop response
  input  logic [NoPorts-1:0]             cr_valid_i,
  output logic [NoPorts-1:0]             cr_ready_o,
  input  logic [5*NoPorts-1:0]           cr_resp_i,
  // snoop data
  input  logic [NoPorts-1:0]             cd_valid_i,
  output logic [NoPorts-1:0]             cd_ready_o,
  input  logic [DataWidth*NoPorts-1:0]   cd_data_i,
  input  logic [NoPorts-1:0]             cd_last_i,
  // memory read
  output logic                           mem_ar_valid_o,
  input  logic                           mem_ar_ready_i,
  output logic [AddrWidth-1:0]           mem_ar_addr_o,
  output logic [IdWidth-1:0]             mem_ar_id_o,
  input  logic                           mem_r_valid_i,
  output logic                           mem_r_ready_o,
  input  logic [DataWidth-1:0]           mem_r_data_i,
  input  logic                           mem_r_last_i,
  // read data
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [DataWidth-1:0]           r_data_o,
  output logic [IdWidth-1:0]             r_id_o,
  output logic [3:0]                     r_resp_o,
  output logic                           r_last_o
);

  localparam int unsigned RespW = 5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNP_REQ  = 3'd1,
    SNP_RESP = 3'd2,
    CD_FWD   = 3'd3,
    MEM_REQ  = 3'd4,
    MEM_FWD  = 3'd5
  } state_e;

  state_e state_q, state_d;

  // transaction latches
  logic [AddrWidth-1:0] addr_q;
  logic [IdWidth-1:0]   id_q;
  logic [PortIdxW-1:0]  port_q;
  logic [3:0]           snoop_q;

  // per-port bookkeeping
  logic [NoPorts-1:0]   ac_pend_q;
  logic [NoPorts-1:0]   cr_pend_q;
  logic [NoPorts-1:0]   dt_q;
  logic [NoPorts-1:0]   pd_q;
  logic [NoPorts-1:0]   drain_q;
  logic                 shared_q;
  logic                 err_q;
  logic [PortIdxW-1:0]  sel_q;
  logic                 pass_dirty_q;
  logic                 sel_done_q;

  // combinational helpers
  logic [NoPorts-1:0]   cr_dt, cr_err, cr_pd, cr_sh, cr_wu_unused;
  logic [NoPorts-1:0]   cr_hs;
  logic [NoPorts-1:0]   ac_pend_nxt, cr_pend_nxt;
  logic [NoPorts-1:0]   dt_nxt, pd_nxt, drain_nxt, drain_last_hs;
  logic [PortIdxW-1:0]  sel_nxt;
  logic [DataWidth-1:0] cd_data_sel;
  logic                 cd_valid_sel, cd_last_sel;
  logic                 sel_hs, sel_last_hs, cd_done;

  // one-hot decode of a port index
  function automatic logic [NoPorts-1:0] port_oh(input logic [PortIdxW-1:0] p);
    logic [NoPorts-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NoPorts); i++) begin
      oh[i] = (p == PortIdxW'(i));
    end
    return oh;
  endfunction

  // split CRRESP fields and compute handshake/bookkeeping next values
  always_comb begin
    cr_dt        = '0;
    cr_err       = '0;
    cr_pd        = '0;
    cr_sh        = '0;
    cr_wu_unused = '0;
    cd_data_sel  = '0;
    sel_nxt      = '0;
    for (int i = 0; i < int'(NoPorts); i++) begin
      cr_dt[i]        = cr_resp_i[RespW*i + 0];
      cr_err[i]       = cr_resp_i[RespW*i + 1];
      cr_pd[i]        = cr_resp_i[RespW*i + 2];
      cr_sh[i]        = cr_resp_i[RespW*i + 3];
      cr_wu_unused[i] = cr_resp_i[RespW*i + 4];
      if (sel_q == PortIdxW'(i)) begin
        cd_data_sel = cd_data_i[DataWidth*i +: DataWidth];
      end
    end

    ac_pend_nxt = ac_pend_q & ~ac_ready_i;
    cr_hs       = (state_q == SNP_RESP) ? (cr_pend_q & cr_valid_i) : '0;
    cr_pend_nxt = cr_pend_q & ~cr_hs;
    dt_nxt      = dt_q | (cr_hs & cr_dt);
    pd_nxt      = pd_q | (cr_hs & cr_pd);

    // lowest-index data-transfer port wins
    for (int i = int'(NoPorts) - 1; i >= 0; i--) begin
      if (dt_nxt[i]) sel_nxt = PortIdxW'(i);
    end

    cd_valid_sel  = cd_valid_i[sel_q];
    cd_last_sel   = cd_last_i[sel_q];
    sel_hs        = (state_q == CD_FWD) && cd_valid_sel && r_ready_i && !sel_done_q;
    sel_last_hs   = sel_hs && cd_last_sel;
    drain_last_hs = drain_q & cd_valid_i & cd_last_i;
    drain_nxt     = drain_q & ~drain_last_hs;
    cd_done       = (sel_done_q || sel_last_hs) && (drain_nxt == '0);
  end

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ar_valid_i) state_d = SNP_REQ;
      SNP_REQ:  if (ac_pend_nxt == '0) state_d = SNP_RESP;
      SNP_RESP: if (cr_pend_nxt == '0) state_d = (dt_nxt != '0) ? CD_FWD : MEM_REQ;
      CD_FWD:   if (cd_done) state_d = IDLE;
      MEM_REQ:  if (mem_ar_ready_i) state_d = MEM_FWD;
      MEM_FWD:  if (mem_r_valid_i && r_ready_i && mem_r_last_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // output logic; data paths are pass-through, valids never look at readies
  always_comb begin
    ar_ready_o     = 1'b0;
    ac_valid_o     = '0;
    cr_ready_o     = '0;
    cd_ready_o     = '0;
    mem_ar_valid_o = 1'b0;
    mem_r_ready_o  = 1'b0;
    r_valid_o      = 1'b0;
    r_data_o       = '0;
    r_last_o       = 1'b0;
    ac_addr_o      = addr_q;
    ac_snoop_o     = snoop_q;
    mem_ar_addr_o  = addr_q;
    mem_ar_id_o    = id_q;
    r_id_o         = id_q;
    r_resp_o       = {shared_q, pass_dirty_q, err_q ? 2'b10 : 2'b00};
    case (state_q)
      IDLE:     ar_ready_o = 1'b1;
      SNP_REQ:  ac_valid_o = ac_pend_q;
      SNP_RESP: cr_ready_o = cr_pend_q;
      CD_FWD: begin
        r_valid_o         = cd_valid_sel && !sel_done_q;
        r_data_o          = cd_data_sel;
        r_last_o          = cd_last_sel;
        cd_ready_o        = drain_q;
        cd_ready_o[sel_q] = r_ready_i && !sel_done_q;
      end
      MEM_REQ:  mem_ar_valid_o = 1'b1;
      MEM_FWD: begin
        r_valid_o     = mem_r_valid_i;
        r_data_o      = mem_r_data_i;
        r_last_o      = mem_r_last_i;
        mem_r_ready_o = r_ready_i;
      end
      default: ;
    endcase
  end

  // transaction latches and per-port bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      id_q         <= '0;
      port_q       <= '0;
      snoop_q      <= '0;
      ac_pend_q    <= '0;
      cr_pend_q    <= '0;
      dt_q         <= '0;
      pd_q         <= '0;
      drain_q      <= '0;
      shared_q     <= 1'b0;
      err_q        <= 1'b0;
      sel_q        <= '0;
      pass_dirty_q <= 1'b0;
      sel_done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ar_valid_i) begin
          addr_q       <= ar_addr_i;
          id_q         <= ar_id_i;
          port_q       <= ar_port_i;
          snoop_q      <= ar_snoop_i;
          ac_pend_q    <= ~port_oh(ar_port_i);
          cr_pend_q    <= '0;
          dt_q         <= '0;
          pd_q         <= '0;
          drain_q      <= '0;
          shared_q     <= 1'b0;
          err_q        <= 1'b0;
          sel_q        <= '0;
          pass_dirty_q <= 1'b0;
          sel_done_q   <= 1'b0;
        end
        SNP_REQ: begin
          ac_pend_q <= ac_pend_nxt;
          if (ac_pend_nxt == '0) cr_pend_q <= ~port_oh(port_q);
        end
        SNP_RESP: begin
          cr_pend_q <= cr_pend_nxt;
          dt_q      <= dt_nxt;
          pd_q      <= pd_nxt;
          shared_q  <= shared_q | (|(cr_hs & cr_sh));
          err_q     <= err_q | (|(cr_hs & cr_err));
          if (cr_pend_nxt == '0) begin
            sel_q        <= sel_nxt;
            pass_dirty_q <= (dt_nxt != '0) && pd_nxt[sel_nxt];
            drain_q      <= dt_nxt & ~port_oh(sel_nxt);
          end
        end
        CD_FWD: begin
          drain_q <= drain_nxt;
          if (sel_last_hs) sel_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ace_ccu_snoop_ctrl.sv
// Directed bench for ace_ccu_snoop_ctrl with NoPorts=4.
module tb_ace_ccu_snoop_ctrl;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 6;
  localparam int unsigned PW = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  logic ar_valid_i, ar_ready_o;
  logic [AW-1:0] ar_addr_i;
  logic [IW-1:0] ar_id_i;
  logic [PW-1:0] ar_port_i;
  logic [3:0] ar_snoop_i;
  logic [NP-1:0] ac_valid_o, ac_ready_i;
  logic [AW-1:0] ac_addr_o;
  logic [3:0] ac_snoop_o;
  logic [NP-1:0] cr_valid_i, cr_ready_o;
  logic [5*NP-1:0] cr_resp_i;
  logic [NP-1:0] cd_valid_i, cd_ready_o, cd_last_i;
  logic [DW*NP-1:0] cd_data_i;
  logic mem_ar_valid_o, mem_ar_ready_i;
  logic [AW-1:0] mem_ar_addr_o;
  logic [IW-1:0] mem_ar_id_o;
  logic mem_r_valid_i, mem_r_ready_o, mem_r_last_i;
  logic [DW-1:0] mem_r_data_i;
  logic r_valid_o, r_ready_i, r_last_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic [3:0] r_resp_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  ace_ccu_snoop_ctrl #(
    .NoPorts(NP), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .PortIdxW(PW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
    .ar_id_i(ar_id_i), .ar_port_i(ar_port_i), .ar_snoop_i(ar_snoop_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
    .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
    .cd_last_i(cd_last_i),
    .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i),
    .mem_ar_addr_o(mem_ar_addr_o), .mem_ar_id_o(mem_ar_id_o),
    .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
    .mem_r_data_i(mem_r_data_i), .mem_r_last_i(mem_r_last_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .r_id_o(r_id_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o)
  );

  typedef struct {
    logic [PW-1:0]  port;
    logic [AW-1:0]  addr;
    logic [IW-1:0]  id;
    logic [3:0]     snoop;
    logic [5*NP-1:0] cr;      // responses of the targets (originator slot ignored)
    logic [NP-1:0]  exp_ac;
    logic           exp_mem;
    logic [PW-1:0]  exp_sel;
    logic [3:0]     exp_resp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] cd_beat(input int p, input int b);
    return {32'hCAFE_0000 + 32'(p), 32'h100 + 32'(b)};
  endfunction

  function automatic logic [63:0] mem_beat(input int b);
    return {32'hFEED_0000, 32'(b)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    ar_valid_i = 0; ar_addr_i = '0; ar_id_i = '0; ar_port_i = '0; ar_snoop_i = '0;
    ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
    cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0;
    mem_ar_ready_i = 0; mem_r_valid_i = 0; mem_r_data_i = '0; mem_r_last_i = 0;
    r_ready_i = 0;
  endtask

  task automatic send_ar(input logic [PW-1:0] p, input logic [AW-1:0] a,
                         input logic [IW-1:0] id, input logic [3:0] sn);
    int n = 0;
    while (!ar_ready_o && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready_wait", 64'(ar_ready_o), 64'd1);
    ar_valid_i = 1; ar_port_i = p; ar_addr_i = a; ar_id_i = id; ar_snoop_i = sn;
    tick();
    ar_valid_i = 0;
  endtask

  task automatic send_cr(input logic [NP-1:0] m, input logic [5*NP-1:0] resp);
    cr_valid_i = m; cr_resp_i = resp;
    tick();
    cr_valid_i = '0; cr_resp_i = '0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [NP-1:0] dtm;
    logic [5*NP-1:0] resp;
    dtm = '0;
    for (int i = 0; i < int'(NP); i++) dtm[i] = v.cr[5*i] && (i != int'(v.port));
    send_ar(v.port, v.addr, v.id, v.snoop);
    check("ac_valid_mask", 64'(ac_valid_o), 64'(v.exp_ac));
    check("ac_addr", ac_addr_o, v.addr);
    check("ac_snoop", 64'(ac_snoop_o), 64'(v.snoop));
    check("cr_ready_in_snp_req", 64'(cr_ready_o), 64'd0);
    ac_ready_i = '1;
    tick();
    ac_ready_i = '0;
    check("ac_valid_done", 64'(ac_valid_o), 64'd0);
    check("cr_ready_mask", 64'(cr_ready_o), 64'(v.exp_ac));
    // originator always reports a full garbage response that must be ignored
    resp = v.cr | ((5*NP)'(5'b01111) << (5*int'(v.port)));
    send_cr('1, resp);
    check("cr_ready_done", 64'(cr_ready_o), 64'd0);
    if (v.exp_mem) begin
      check("mem_ar_valid", 64'(mem_ar_valid_o), 64'd1);
      check("mem_ar_addr", mem_ar_addr_o, v.addr);
      check("mem_ar_id", 64'(mem_ar_id_o), 64'(v.id));
      mem_ar_ready_i = 1;
      tick();
      mem_ar_ready_i = 0;
      check("mem_ar_valid_off", 64'(mem_ar_valid_o), 64'd0);
      r_ready_i = 1;
      for (int b = 0; b < 4; b++) begin
        mem_r_valid_i = 1; mem_r_data_i = mem_beat(b); mem_r_last_i = (b == 3);
        #1;
        check("mem_r_valid", 64'(r_valid_o), 64'd1);
        check("mem_r_data", r_data_o, mem_beat(b));
        check("mem_r_last", 64'(r_last_o), 64'(b == 3));
        check("mem_r_ready", 64'(mem_r_ready_o), 64'd1);
        check("mem_r_id", 64'(r_id_o), 64'(v.id));
        check("mem_r_resp", 64'(r_resp_o), 64'(v.exp_resp));
        tick();
      end
      mem_r_valid_i = 0; mem_r_last_i = 0; r_ready_i = 0;
    end else begin
      check("no_mem_ar", 64'(mem_ar_valid_o), 64'd0);
      r_ready_i = 1;
      cd_valid_i = dtm;
      for (int b = 0; b < 4; b++) begin
        for (int p = 0; p < int'(NP); p++) cd_data_i[DW*p +: DW] = cd_beat(p, b);
        cd_last_i = (b == 3) ? dtm : '0;
        #1;
        check("cd_r_valid", 64'(r_valid_o), 64'd1);
        check("cd_r_data", r_data_o, cd_beat(int'(v.exp_sel), b));
        check("cd_r_last", 64'(r_last_o), 64'(b == 3));
        check("cd_ready_mask", 64'(cd_ready_o), 64'(dtm));
        check("cd_r_resp", 64'(r_resp_o), 64'(v.exp_resp));
        check("cd_r_id", 64'(r_id_o), 64'(v.id));
        tick();
      end
      cd_valid_i = '0; cd_last_i = '0; r_ready_i = 0;
    end
    check("back_idle", 64'(ar_ready_o), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int n;
    logic hs;
    clear_inputs();
    rst_i = 1;

    //         port   addr         id     snoop  cr {p3,p2,p1,p0}                                exp_ac    mem   sel   resp
    vecs[0] = '{2'd1, 64'h1000, 6'h05, 4'h1, {5'b00000, 5'b00000, 5'b00000, 5'b00000}, 4'b1101, 1'b1, 2'd0, 4'b0000};
    vecs[1] = '{2'd1, 64'h2000, 6'h11, 4'h2, {5'b01000, 5'b00101, 5'b00000, 5'b00000}, 4'b1101, 1'b0, 2'd2, 4'b1100};
    vecs[2] = '{2'd2, 64'h2040, 6'h22, 4'h0, {5'b00000, 5'b00000, 5'b00000, 5'b00010}, 4'b1011, 1'b1, 2'd0, 4'b0010};
    vecs[3] = '{2'd0, 64'h3080, 6'h33, 4'h7, {5'b00001, 5'b00000, 5'b01010, 5'b00000}, 4'b1110, 1'b0, 2'd3, 4'b1010};
    vecs[4] = '{2'd3, 64'h40C0, 6'h3F, 4'hB, {5'b00000, 5'b00000, 5'b00101, 5'b00001}, 4'b0111, 1'b0, 2'd0, 4'b0000};

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    check("rst_ac_valid", 64'(ac_valid_o), 64'd0);
    check("rst_cr_ready", 64'(cr_ready_o), 64'd0);
    check("rst_cd_ready", 64'(cd_ready_o), 64'd0);
    check("rst_mem_ar_valid", 64'(mem_ar_valid_o), 64'd0);
    check("rst_r_valid", 64'(r_valid_o), 64'd0);
    rst_i = 0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // staggered snoop acceptance and a stalling R consumer
    send_ar(2'd1, 64'h5000, 6'h07, 4'h1);
    ac_ready_i = 4'b0001;
    tick();
    check("stag_ac_1", 64'(ac_valid_o), 64'b1100);
    check("stag_cr_hold", 64'(cr_ready_o), 64'd0);
    ac_ready_i = 4'b0100;
    tick();
    check("stag_ac_2", 64'(ac_valid_o), 64'b1000);
    ac_ready_i = 4'b1000;
    tick();
    ac_ready_i = '0;
    check("stag_cr_ready", 64'(cr_ready_o), 64'b1101);
    send_cr(4'b1101, {5'b00000, 5'b00001, 5'b00000, 5'b00000});
    cd_valid_i = 4'b0100;
    b = 0;
    n = 0;
    while (b < 4 && n < 40) begin
      r_ready_i = n[0];
      cd_data_i[DW*2 +: DW] = cd_beat(2, b);
      cd_last_i = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      check("stag_r_valid", 64'(r_valid_o), 64'd1);
      check("stag_r_data", r_data_o, cd_beat(2, b));
      check("stag_cd_ready", 64'(cd_ready_o), 64'({1'b0, r_ready_i, 2'b00}));
      hs = r_ready_i;
      tick();
      if (hs) b++;
      n++;
    end
    cd_valid_i = '0; cd_last_i = '0; r_ready_i = 0;
    check("stag_beats", 64'(b), 64'd4);
    check("stag_idle", 64'(ar_ready_o), 64'd1);

    // two data ports: port 0 forwarded, port 3 drained late
    send_ar(2'd1, 64'h6000, 6'h09, 4'h1);
    ac_ready_i = '1;
    tick();
    ac_ready_i = '0;
    send_cr(4'b1101, {5'b00001, 5'b00000, 5'b00000, 5'b00001});
    r_ready_i = 1;
    cd_valid_i = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      cd_data_i[0 +: DW] = cd_beat(0, k);
      cd_last_i = (k == 3) ? 4'b0001 : 4'b0000;
      #1;
      check("drain_sel_data", r_data_o, cd_beat(0, k));
      check("drain_cd_ready", 64'(cd_ready_o), 64'b1001);
      tick();
    end
    cd_valid_i = '0; cd_last_i = '0;
    check("drain_r_valid_off", 64'(r_valid_o), 64'd0);
    check("drain_ar_blocked", 64'(ar_ready_o), 64'd0);
    cd_valid_i = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      cd_data_i[DW*3 +: DW] = cd_beat(3, k);
      cd_last_i = (k == 1) ? 4'b1000 : 4'b0000;
      #1;
      check("drain_other_ready", 64'(cd_ready_o), 64'b1000);
      check("drain_other_no_r", 64'(r_valid_o), 64'd0);
      tick();
    end
    cd_valid_i = '0; cd_last_i = '0; r_ready_i = 0;
    check("drain_idle", 64'(ar_ready_o), 64'd1);

    // reset in the middle of CD forwarding
    send_ar(2'd1, 64'h7000, 6'h0A, 4'h1);
    ac_ready_i = '1;
    tick();
    ac_ready_i = '0;
    send_cr(4'b1101, {5'b00000, 5'b00001, 5'b00000, 5'b00000});
    r_ready_i = 1;
    cd_valid_i = 4'b0100;
    cd_data_i[DW*2 +: DW] = cd_beat(2, 0);
    tick();
    check("mid_r_valid", 64'(r_valid_o), 64'd1);
    rst_i = 1;
    #1;
    check("abort_r_valid", 64'(r_valid_o), 64'd0);
    check("abort_cd_ready", 64'(cd_ready_o), 64'd0);
    check("abort_ac_valid", 64'(ac_valid_o), 64'd0);
    check("abort_mem_ar_valid", 64'(mem_ar_valid_o), 64'd0);
    check("abort_ar_ready", 64'(ar_ready_o), 64'd1);
    tick();
    check("abort_r_valid_next", 64'(r_valid_o), 64'd0);
    clear_inputs();
    rst_i = 0;
    tick();
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ace_ccu_snoop_ctrl.md
ACE_CCU_SNOOP_CTRL -- requirements
Module: ace_ccu_snoop_ctrl

Interface
REQ-001 Parameter NoPorts, default 4: number of ACE masters snooped; legal range 2..16.
REQ-002 Parameter AddrWidth, default 64: address width.
REQ-003 Parameter DataWidth, default 64: width of R and CD data.
REQ-004 Parameter IdWidth, default 6: transaction ID width.
REQ-005 Parameter PortIdxW, default $clog2(NoPorts): port index width.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-007 Clock and reset ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
REQ-008 Read-request ports SHALL be:
- ar_valid_i/ar_ready_o  in/out  1  arbitrated read request handshake
- ar_addr_i  in  AddrWidth  read address
- ar_id_i  in  IdWidth  read ID
- ar_port_i  in  PortIdxW  index of the originating port
- ar_snoop_i  in  4  ARSNOOP
REQ-009 Snoop-address ports SHALL be:
- ac_valid_o/ac_ready_i  out/in  NoPorts  per-port handshake
- ac_addr_o  out  AddrWidth  snoop address
- ac_snoop_o  out  4  ACSNOOP
REQ-010 Snoop-response ports SHALL be:
- cr_valid_i/cr_ready_o  in/out  NoPorts  per-port handshake
- cr_resp_i  in  5*NoPorts  per-port CRRESP; bit 0 DataTransfer, bit 1 Error, bit 2 PassDirty, bit 3 IsShared, bit 4 WasUnique
REQ-011 Snoop-data ports SHALL be:
- cd_valid_i/cd_ready_o  in/out  NoPorts  per-port handshake
- cd_data_i  in  DataWidth*NoPorts  snoop data
- cd_last_i  in  NoPorts  last snoop-data beat
REQ-012 Memory-read ports SHALL be:
- mem_ar_valid_o/mem_ar_ready_i  out/in  1  memory read handshake
- mem_ar_addr_o  out  AddrWidth  memory read address
- mem_ar_id_o  out  IdWidth  memory read ID
- mem_r_valid_i/mem_r_ready_o  in/out  1  memory read-data handshake
- mem_r_data_i  in  DataWidth  memory read data
- mem_r_last_i  in  1  last memory read-data beat
REQ-013 Read-data ports SHALL be:
- r_valid_o/r_ready_i  out/in  1  read-data handshake
- r_data_o  out  DataWidth  read data
- r_id_o  out  IdWidth  read ID
- r_resp_o  out  4  RRESP; [1:0] OKAY/SLVERR, [2] PassDirty, [3] IsShared
- r_last_o  out  1  last read-data beat

Function
REQ-014 The FSM SHALL have states IDLE, SNP_REQ, SNP_RESP, CD_FWD, MEM_REQ and MEM_FWD, and SHALL handle one transaction at a time.
REQ-015 IDLE behaviour:
- ar_ready_o=1
- on the AR handshake, latch addr, id, port and snoop; build target mask = all ports except ar_port_i
- go to SNP_REQ
REQ-016 SNP_REQ behaviour:
- ac_valid_o[i]=1 for each pending target
- clear the pending bit on ac_ready_i[i]
- ac_snoop_o = latched ARSNOOP
- go to SNP_RESP when all pending bits are clear; the last acceptance and the state change occur in the same cycle
REQ-017 SNP_RESP behaviour:
- cr_ready_o[i]=1 for each target not yet responded
- record DataTransfer; OR together IsShared and Error
- select the lowest-index port with DataTransfer=1; record its PassDirty
- when all targets have responded, go to CD_FWD if any DataTransfer is set, else MEM_REQ
REQ-018 CD_FWD behaviour:
- r_valid_o = cd_valid_i[sel]; cd_ready_o[sel] = r_ready_i
- r_data_o = cd_data_i[sel]; r_last_o = cd_last_i[sel]
- cd_ready_o = 1 for every other DataTransfer port, and that data is discarded (drained)
- go to IDLE once the selected last beat has transferred and all other DataTransfer ports have delivered their last beats
REQ-019 MEM_REQ behaviour:
- mem_ar_valid_o=1 with the latched addr and id
- go to MEM_FWD on mem_ar_ready_i
REQ-020 MEM_FWD behaviour:
- pass mem_r through to r combinationally; mem_r_ready_o = r_ready_i
- go to IDLE on the handshake with mem_r_last_i=1
REQ-021 r_id_o SHALL equal the latched ID.
REQ-022 r_resp_o SHALL be built as follows:
- [1:0] = 2'b10 if Error was seen, else 2'b00
- [2] = PassDirty of the selected port, 0 on the memory path
- [3] = OR of IsShared
REQ-023 Valid signals SHALL NOT depend combinationally on the matching ready signal.
REQ-024 A beat held with valid=1 and ready=0 SHALL keep its data stable.
REQ-025 The CR-valid bit of the originating port, and of any port already responded, SHALL be ignored; its cr_ready_o stays 0.
REQ-026 Simultaneous CR responses from all targets in one cycle SHALL complete SNP_RESP in that cycle.

Reset
REQ-027 While rst_i=1, the block SHALL set state=IDLE, clear all masks and latches, and drive every valid and ready output to 0, except ar_ready_o=1.
REQ-028 Assertion of rst_i mid-transaction SHALL abort the transaction immediately, with no further handshakes.

Verification
REQ-029 NoPorts=4: AR from port 1 at 0x1000 -> AC to ports 0, 2 and 3 only; all CR=0 -> mem AR at 0x1000; 4 memory beats forwarded; r_resp_o=0.
REQ-030 Port 2 returns CR DataTransfer|PassDirty and port 3 returns IsShared -> R data taken from port 2 CD; no mem AR; r_resp_o=4'b1100.
REQ-031 Ports 0 and 3 both return DataTransfer -> R data from port 0; port 3 CD drained; next AR accepted only after both last beats.
REQ-032 Run with ac_ready_i staggered over 3 cycles and r_ready_i toggling -> no lost or duplicated beat; data stable while stalled.
REQ-033 rst_i asserted in CD_FWD -> next cycle all valids are 0 and ar_ready_o=1; a fresh AR then completes normally.
REQ-034 One port returns CR Error and none return data -> memory path is taken; r_resp_o[1:0]=2'b10.
